// File: rtl/joy_db15_pkg.sv
// Shared types and sizing for the DB15 joystick serial transmitter.
package joy_db15_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   localparam int DEF_NBITS  = 12;

   function automatic int frame_bits(input int nbits);
      return 2 * nbits;
   endfunction

   localparam int FRAME_BITS = frame_bits(DEF_NBITS);
endpackage

// File: rtl/joy_db15_if.sv
// Host-side DB15 wires plus device status flags, bundled for the transmitter.
interface joy_db15_if
   import joy_db15_pkg::*;
#(
   parameter int NBITS = DEF_NBITS
);
   logic             joy_clk;
   logic             joy_load;
   logic [NBITS-1:0] joy1;
   logic [NBITS-1:0] joy2;
   logic             joy_data;
   logic             frame_start;
   logic             frame_done;
   logic             busy;

   modport master (
      output joy_clk, joy_load, joy1, joy2,
      input  joy_data, frame_start, frame_done, busy
   );

   modport slave (
      input  joy_clk, joy_load, joy1, joy2,
      output joy_data, frame_start, frame_done, busy
   );
endinterface

// File: rtl/joy_db15_sync.sv
// Multi-flop synchronizer for one async host wire, with rise/fall pulses
// derived from one extra history flop.
module db15_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;
endmodule

// File: rtl/joy_db15_tx.sv
// Device end of the DB15 serial joystick link, behaving like a 74x165 chain:
// transparent parallel load while host load is low, one bit per host clock rise.
module joy_db15_tx
   import joy_db15_pkg::*;
#(
   parameter int   NBITS       = DEF_NBITS,
   parameter int   SYNC_STAGES = 2,
   parameter logic TAIL        = 1'b1
) (
   input  logic      clk_sys,
   input  logic      reset,
   joy_db15_if.slave bus
);
   localparam int            FB       = frame_bits(NBITS);
   localparam int            IW       = $clog2(FB + 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(FB - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(FB);

   state_t        state, state_nxt;
   logic [FB-1:0] sr, sr_nxt, frame_n, sr_shifted;
   logic [IW-1:0] idx, idx_nxt;
   logic          start_q, start_nxt;
   logic          done_q, done_nxt;
   logic          clk_rise, load_q, load_rise;
   logic          clk_q_unused, clk_fall_unused, load_fall_unused;

   db15_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk_sync (
      .clk  (clk_sys),
      .rst  (reset),
      .din  (bus.joy_clk),
      .q    (clk_q_unused),
      .rise (clk_rise),
      .fall (clk_fall_unused)
   );

   db15_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_load_sync (
      .clk  (clk_sys),
      .rst  (reset),
      .din  (bus.joy_load),
      .q    (load_q),
      .rise (load_rise),
      .fall (load_fall_unused)
   );

   // Wire is active-low, so the register holds the inverted frame word.
   assign frame_n    = ~{bus.joy2, bus.joy1};
   assign sr_shifted = {TAIL, sr[FB-1:1]};

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sr      <= '1;
         idx     <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         sr      <= sr_nxt;
         idx     <= idx_nxt;
         start_q <= start_nxt;
         done_q  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      idx_nxt   = idx;
      start_nxt = 1'b0;
      done_nxt  = 1'b0;
      // Load low overrides everything, including a clock edge seen the same cycle.
      if (!load_q) begin
         state_nxt = LOAD;
         sr_nxt    = frame_n;
         idx_nxt   = '0;
      end else begin
         unique case (state)
            LOAD: begin
               if (load_rise) begin
                  state_nxt = SHIFT;
                  start_nxt = 1'b1;
               end
            end
            SHIFT: begin
               if (clk_rise) begin
                  sr_nxt  = sr_shifted;
                  idx_nxt = idx + IW'(1);
                  if (idx == IDX_LAST) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end
            IDLE: begin
               if (clk_rise) begin
                  sr_nxt = sr_shifted;
                  if (idx != IDX_MAX) idx_nxt = idx + IW'(1);
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign bus.joy_data    = sr[0];
   assign bus.busy        = (state == SHIFT);
   assign bus.frame_start = start_q;
   assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: host-side wire stimulus, expected wire bits queued
// as each frame is loaded and popped as the host clocks them out.
module tb_joy_db15_tx;
   import joy_db15_pkg::*;

   logic clk_sys = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   int   start_cnt = 0;
   int   done_cnt = 0;
   logic exp_q[$];

   joy_db15_if #(.NBITS(DEF_NBITS)) bus ();

   joy_db15_tx #(.NBITS(DEF_NBITS), .SYNC_STAGES(2), .TAIL(1'b1)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (bus.frame_start === 1'b1) start_cnt++;
      if (bus.frame_done === 1'b1) done_cnt++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      if (exp_q.size() == 0) begin
         bad++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         check(tag, {31'd0, bus.joy_data}, {31'd0, exp_q.pop_front()});
      end
   endtask

   // Hold load low, optionally change joy1 mid-load, release, then queue the expected wire.
   task automatic do_load(input logic [11:0] j1a, input logic [11:0] j1b, input logic [11:0] j2);
      logic [23:0] f;
      bus.joy1 = j1a;
      bus.joy2 = j2;
      bus.joy_load = 1'b0;
      cyc(4);
      bus.joy1 = j1b;
      cyc(4);
      bus.joy_load = 1'b1;
      cyc(6);
      bus.joy1 = ~j1b;
      f = {j2, j1b};
      exp_q.delete();
      for (int k = 0; k < FRAME_BITS; k++) exp_q.push_back(~f[k]);
      exp_q.push_back(1'b1);
   endtask

   task automatic host_edge();
      bus.joy_clk = 1'b1;
      cyc(6);
      bus.joy_clk = 1'b0;
      cyc(6);
   endtask

   initial begin
      int d0;
      int s0;
      int c;
      reset = 1'b1;
      bus.joy_clk = 1'b0;
      bus.joy_load = 1'b1;
      bus.joy1 = '0;
      bus.joy2 = '0;
      cyc(3);
      check("rst_data", {31'd0, bus.joy_data}, 32'd1);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_start", {31'd0, bus.frame_start}, 32'd0);
      check("rst_done", {31'd0, bus.frame_done}, 32'd0);
      reset = 1'b0;
      cyc(5);

      // Single bit at each end of the frame.
      s0 = start_cnt;
      do_load(12'h001, 12'h001, 12'h800);
      check("t2_start", start_cnt, s0 + 1);
      check("t2_busy", {31'd0, bus.busy}, 32'd1);
      pop_chk("t2_bit0");
      d0 = done_cnt;
      for (int i = 0; i < FRAME_BITS; i++) begin
         host_edge();
         pop_chk("t2_bit");
         if (i == FRAME_BITS - 2) check("t2_no_early_done", done_cnt, d0);
      end
      check("t2_done", done_cnt, d0 + 1);
      check("t2_idle", {31'd0, bus.busy}, 32'd0);

      // Extra clocks after the frame only shift the tail level.
      d0 = done_cnt;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(1'b1);
         host_edge();
         pop_chk("t3_tail");
      end
      check("t3_no_done", done_cnt, d0);
      check("t3_idx_sat", {27'd0, dut.idx}, 32'd24);

      // Last sample during load wins.
      s0 = start_cnt;
      d0 = done_cnt;
      do_load(12'h0F0, 12'h00F, 12'h000);
      check("t4_start_once", start_cnt, s0 + 1);
      pop_chk("t4_bit0");
      for (int i = 0; i < FRAME_BITS; i++) begin
         host_edge();
         pop_chk("t4_bit");
      end
      check("t4_done", done_cnt, d0 + 1);

      // Abort after 10 edges, then restart from bit0.
      d0 = done_cnt;
      do_load(12'h0AA, 12'h0AA, 12'h055);
      pop_chk("t5_bit0");
      for (int i = 0; i < 10; i++) begin
         host_edge();
         pop_chk("t5_bit");
      end
      bus.joy_load = 1'b0;
      c = 0;
      for (int k = 1; k <= 10; k++) begin
         cyc(1);
         if (bus.busy === 1'b0) begin
            c = k;
            break;
         end
      end
      check("t5_busy_drop_ok", {31'd0, (c >= 1 && c <= 3)}, 32'd1);
      check("t5_no_done", done_cnt, d0);
      do_load(12'h0AA, 12'h0AA, 12'h055);
      pop_chk("t5_restart_bit0");
      for (int i = 0; i < FRAME_BITS; i++) begin
         host_edge();
         pop_chk("t5_restart_bit");
      end
      check("t5_done_after_restart", done_cnt, d0 + 1);

      // Reset in the middle of a frame.
      do_load(12'hFFF, 12'hFFF, 12'hFFF);
      for (int i = 0; i < 3; i++) host_edge();
      check("t1_pre_busy", {31'd0, bus.busy}, 32'd1);
      s0 = start_cnt;
      d0 = done_cnt;
      reset = 1'b1;
      cyc(1);
      check("t1_rst_data", {31'd0, bus.joy_data}, 32'd1);
      check("t1_rst_busy", {31'd0, bus.busy}, 32'd0);
      cyc(3);
      reset = 1'b0;
      cyc(5);
      check("t1_idle_data", {31'd0, bus.joy_data}, 32'd1);
      check("t1_idle_busy", {31'd0, bus.busy}, 32'd0);
      check("t1_no_start", start_cnt, s0);
      check("t1_no_done", done_cnt, d0);

      // Wire-to-output latency, then a clock edge coincident with load.
      do_load(12'h002, 12'h002, 12'h000);
      pop_chk("t6_bit0");
      bus.joy_clk = 1'b1;
      cyc(2);
      check("t6_lat_t2_old", {31'd0, bus.joy_data}, 32'd1);
      cyc(1);
      check("t6_lat_t3_new", {31'd0, bus.joy_data}, 32'd0);
      bus.joy_clk = 1'b0;
      cyc(6);
      bus.joy1 = 12'h002;
      bus.joy_clk = 1'b1;
      bus.joy_load = 1'b0;
      cyc(8);
      check("t6_coinc_busy", {31'd0, bus.busy}, 32'd0);
      check("t6_coinc_idx", {27'd0, dut.idx}, 32'd0);
      bus.joy_load = 1'b1;
      cyc(6);
      check("t6_coinc_shift_busy", {31'd0, bus.busy}, 32'd1);
      check("t6_coinc_no_shift", {31'd0, bus.joy_data}, 32'd1);
      bus.joy_clk = 1'b0;
      cyc(6);
      bus.joy_clk = 1'b1;
      cyc(6);
      check("t6_next_bit1", {31'd0, bus.joy_data}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
